// File: rtl/dcache_s2_nway.sv
// dcache_s2_nway: N-way data cache stage 2 (hit detect, victim write-back, refill/merge, uncached access).
// Optional performance counters are built when DCACHE_S2_PERF_EN is defined.
module dcache_s2_nway #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned TAG_W      = 21,
    localparam int unsigned LINE_W    = 32 * LINE_WORDS,
    localparam int unsigned WAY_W     = $clog2(WAYS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic                     req_wr,
    input  logic                     req_cached,
    input  logic [3:0]               req_wen,
    input  logic [31:0]              req_paddr,
    input  logic [31:0]              req_wdata,
    input  logic [WAYS*TAG_W-1:0]    tag_i,
    input  logic [WAYS-1:0]          valid_i,
    input  logic [WAYS-1:0]          dirty_i,
    input  logic [WAYS*LINE_W-1:0]   line_i,
    input  logic                     cpu_ack_i,
    output logic                     axi_rreq_o,
    output logic [31:0]              axi_raddr_o,
    input  logic                     axi_rend_i,
    input  logic [LINE_W-1:0]        axi_rline_i,
    output logic                     axi_wreq_o,
    output logic [31:0]              axi_waddr_o,
    output logic [LINE_W-1:0]        axi_wline_o,
    input  logic                     axi_wend_i,
    output logic                     uc_rreq_o,
    output logic                     uc_wreq_o,
    output logic [31:0]              uc_addr_o,
    output logic [3:0]               uc_wen_o,
    output logic [31:0]              uc_wdata_o,
    input  logic                     uc_rend_i,
    input  logic                     uc_wend_i,
    input  logic [31:0]              uc_rdata_i,
    output logic                     hit_we_o,
    output logic                     fill_we_o,
    output logic [WAY_W-1:0]         way_o,
    output logic [LINE_W-1:0]        fill_line_o,
    output logic                     fill_dirty_o,
    output logic                     stall_o,
`ifdef DCACHE_S2_PERF_EN
    output logic [31:0]              perf_hit_o,
    output logic [31:0]              perf_miss_o,
    output logic [31:0]              perf_wb_o,
`endif
    output logic [31:0]              rdata_o,
    output logic                     rdata_valid_o
);

    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_B  = WORD_W + 2;
    localparam int unsigned IDX_W  = 32 - TAG_W - OFF_B;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_WB     = 6'b000010,
        S_REFILL = 6'b000100,
        S_FILL   = 6'b001000,
        S_UC_RD  = 6'b010000,
        S_UC_WR  = 6'b100000
    } state_e;

    state_e              state_q, state_d;
    logic [WAY_W-1:0]    rr_q, rr_d, vway_q, vway_d;
    logic [TAG_W-1:0]    vtag_q, vtag_d;
    logic [LINE_W-1:0]   wline_q, wline_d, rline_q, rline_d;
    logic [31:0]         held_q, held_d;
    logic                held_vld_q, held_vld_d;
    logic                uc_done_q, uc_done_d;

    logic                req_go;
    logic [TAG_W-1:0]    req_tag;
    logic [WORD_W-1:0]   word_sel;
    logic                hit, has_inv, wb_need;
    logic [WAY_W-1:0]    hit_way, inv_way, vsel;
    logic [31:0]         hit_word;
    logic [LINE_W-1:0]   merged;

    // Reset also masks the live request so every output is quiet while rst_n is low.
    assign req_go   = req_valid & rst_n;
    assign req_tag  = req_paddr[31 -: TAG_W];
    assign word_sel = req_paddr[2 +: WORD_W];

    // Lowest matching way wins; lowest invalid way is the preferred victim.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_i[w] && (tag_i[w*TAG_W +: TAG_W] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_i[w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign vsel     = has_inv ? inv_way : rr_q;
    assign wb_need  = valid_i[vsel] & dirty_i[vsel];
    assign hit_word = line_i[int'(hit_way)*LINE_W + int'(word_sel)*32 +: 32];

    // Write-allocate: store bytes overlay the refilled line before it is installed.
    always_comb begin
        merged = rline_q;
        if (req_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wen[b]) begin
                    merged[int'(word_sel)*32 + b*8 +: 8] = req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        vway_d        = vway_q;
        vtag_d        = vtag_q;
        wline_d       = wline_q;
        rline_d       = rline_q;
        held_d        = held_q;
        held_vld_d    = held_vld_q & ~cpu_ack_i;
        uc_done_d     = 1'b0;
        axi_rreq_o    = 1'b0;
        axi_raddr_o   = '0;
        axi_wreq_o    = 1'b0;
        axi_waddr_o   = '0;
        axi_wline_o   = '0;
        uc_rreq_o     = 1'b0;
        uc_wreq_o     = 1'b0;
        uc_addr_o     = '0;
        uc_wen_o      = '0;
        uc_wdata_o    = '0;
        hit_we_o      = 1'b0;
        fill_we_o     = 1'b0;
        way_o         = '0;
        fill_line_o   = '0;
        fill_dirty_o  = 1'b0;
        stall_o       = 1'b0;
        rdata_o       = '0;
        rdata_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (held_vld_q) begin
                    rdata_o       = held_q;
                    rdata_valid_o = 1'b1;
                end
                // uc_done_q marks the still-present request that just completed uncached.
                if (req_go && !uc_done_q) begin
                    if (req_cached) begin
                        if (hit) begin
                            if (req_wr) begin
                                hit_we_o = 1'b1;
                                way_o    = hit_way;
                            end else if (!held_vld_q) begin
                                rdata_o       = hit_word;
                                rdata_valid_o = 1'b1;
                            end
                        end else begin
                            stall_o = 1'b1;
                            vway_d  = vsel;
                            vtag_d  = tag_i[int'(vsel)*TAG_W +: TAG_W];
                            wline_d = line_i[int'(vsel)*LINE_W +: LINE_W];
                            state_d = wb_need ? S_WB : S_REFILL;
                        end
                    end else begin
                        stall_o = 1'b1;
                        state_d = req_wr ? S_UC_WR : S_UC_RD;
                    end
                end
            end
            S_WB: begin
                stall_o     = 1'b1;
                axi_wreq_o  = 1'b1;
                axi_waddr_o = {vtag_q, req_paddr[OFF_B +: IDX_W], {OFF_B{1'b0}}};
                axi_wline_o = wline_q;
                if (axi_wend_i) state_d = S_REFILL;
            end
            S_REFILL: begin
                stall_o     = 1'b1;
                axi_rreq_o  = 1'b1;
                axi_raddr_o = {req_paddr[31:OFF_B], {OFF_B{1'b0}}};
                if (axi_rend_i) begin
                    rline_d = axi_rline_i;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                fill_we_o    = 1'b1;
                way_o        = vway_q;
                fill_line_o  = merged;
                fill_dirty_o = req_wr;
                rr_d         = rr_q + WAY_W'(1);
                if (!req_wr) begin
                    held_d     = rline_q[int'(word_sel)*32 +: 32];
                    held_vld_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_UC_RD: begin
                stall_o   = 1'b1;
                uc_rreq_o = 1'b1;
                uc_addr_o = req_paddr;
                uc_wen_o  = 4'b1111;
                if (uc_rend_i) begin
                    held_d     = uc_rdata_i;
                    held_vld_d = 1'b1;
                    uc_done_d  = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_UC_WR: begin
                stall_o    = 1'b1;
                uc_wreq_o  = 1'b1;
                uc_addr_o  = req_paddr;
                uc_wen_o   = req_wen;
                uc_wdata_o = req_wdata;
                if (uc_wend_i) begin
                    uc_done_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            vway_q     <= '0;
            vtag_q     <= '0;
            wline_q    <= '0;
            rline_q    <= '0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            uc_done_q  <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            vway_q     <= vway_d;
            vtag_q     <= vtag_d;
            wline_q    <= wline_d;
            rline_q    <= rline_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            uc_done_q  <= uc_done_d;
        end
    end

`ifdef DCACHE_S2_PERF_EN
    logic        ev_look, ev_hit, ev_miss, ev_wb;
    logic [31:0] perf_hit_q, perf_miss_q, perf_wb_q;

    assign ev_look = (state_q == S_IDLE) & req_go & ~uc_done_q & req_cached;
    assign ev_hit  = ev_look & hit;
    assign ev_miss = ev_look & ~hit;
    assign ev_wb   = ev_miss & wb_need;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
            perf_wb_q   <= '0;
        end else begin
            if (ev_hit && (perf_hit_q != '1))   perf_hit_q  <= perf_hit_q + 32'd1;
            if (ev_miss && (perf_miss_q != '1)) perf_miss_q <= perf_miss_q + 32'd1;
            if (ev_wb && (perf_wb_q != '1))     perf_wb_q   <= perf_wb_q + 32'd1;
        end
    end

    assign perf_hit_o  = perf_hit_q;
    assign perf_miss_o = perf_miss_q;
    assign perf_wb_o   = perf_wb_q;
`endif

endmodule

// File: tb/tb_dcache_s2_nway.sv
// Self-checking bench for dcache_s2_nway (WAYS=4): directed scenarios plus random transactions
// checked against a set-level behavioural model with its own round-robin victim counter.
`timescale 1ns/1ps
module tb_dcache_s2_nway;
    localparam int unsigned WAYS       = 4;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned TAG_W      = 21;
    localparam int unsigned LINE_W     = 32 * LINE_WORDS;
    localparam int unsigned WAY_W      = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 0, req_wr = 0, req_cached = 0;
    logic [3:0] req_wen = '0;
    logic [31:0] req_paddr = '0, req_wdata = '0;
    logic [WAYS*TAG_W-1:0] tag_i = '0;
    logic [WAYS-1:0] valid_i = '0, dirty_i = '0;
    logic [WAYS*LINE_W-1:0] line_i = '0;
    logic cpu_ack_i = 0;
    logic axi_rreq_o, axi_wreq_o, uc_rreq_o, uc_wreq_o, hit_we_o, fill_we_o, fill_dirty_o;
    logic stall_o, rdata_valid_o;
    logic [31:0] axi_raddr_o, axi_waddr_o, uc_addr_o, uc_wdata_o, rdata_o;
    logic [3:0] uc_wen_o;
    logic [LINE_W-1:0] axi_wline_o, fill_line_o;
    logic [WAY_W-1:0] way_o;
    logic axi_rend_i = 0, axi_wend_i = 0, uc_rend_i = 0, uc_wend_i = 0;
    logic [LINE_W-1:0] axi_rline_i = '0;
    logic [31:0] uc_rdata_i = '0;
`ifdef DCACHE_S2_PERF_EN
    logic [31:0] perf_hit_o, perf_miss_o, perf_wb_o;
`endif

    always #5 clk = ~clk;

    dcache_s2_nway #(.WAYS(WAYS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr), .req_cached(req_cached),
        .req_wen(req_wen), .req_paddr(req_paddr), .req_wdata(req_wdata), .tag_i(tag_i),
        .valid_i(valid_i), .dirty_i(dirty_i), .line_i(line_i), .cpu_ack_i(cpu_ack_i),
        .axi_rreq_o(axi_rreq_o), .axi_raddr_o(axi_raddr_o), .axi_rend_i(axi_rend_i),
        .axi_rline_i(axi_rline_i), .axi_wreq_o(axi_wreq_o), .axi_waddr_o(axi_waddr_o),
        .axi_wline_o(axi_wline_o), .axi_wend_i(axi_wend_i), .uc_rreq_o(uc_rreq_o),
        .uc_wreq_o(uc_wreq_o), .uc_addr_o(uc_addr_o), .uc_wen_o(uc_wen_o), .uc_wdata_o(uc_wdata_o),
        .uc_rend_i(uc_rend_i), .uc_wend_i(uc_wend_i), .uc_rdata_i(uc_rdata_i),
        .hit_we_o(hit_we_o), .fill_we_o(fill_we_o), .way_o(way_o), .fill_line_o(fill_line_o),
        .fill_dirty_o(fill_dirty_o), .stall_o(stall_o),
`ifdef DCACHE_S2_PERF_EN
        .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o), .perf_wb_o(perf_wb_o),
`endif
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o)
    );

    // Model of the indexed set and of the replacement pointer.
    logic [TAG_W-1:0] s_tag [WAYS];
    logic             s_valid [WAYS];
    logic             s_dirty [WAYS];
    logic [31:0]      s_word [WAYS][LINE_WORDS];
    int m_rr = 0;
    int n_checks = 0;
    int n_fail = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_set();
        for (int w = 0; w < WAYS; w++) begin
            tag_i[w*TAG_W +: TAG_W] = s_tag[w];
            valid_i[w] = s_valid[w];
            dirty_i[w] = s_dirty[w];
            for (int i = 0; i < LINE_WORDS; i++) line_i[w*LINE_W + i*32 +: 32] = s_word[w][i];
        end
    endtask

    task automatic rand_set(input logic [TAG_W-1:0] avoid);
        for (int w = 0; w < WAYS; w++) begin
            do s_tag[w] = TAG_W'($urandom); while (s_tag[w] == avoid);
            s_valid[w] = ($urandom_range(3) != 0);
            s_dirty[w] = 1'($urandom_range(1));
            for (int i = 0; i < LINE_WORDS; i++) s_word[w][i] = $urandom;
        end
    endtask

    function automatic logic [LINE_W-1:0] line_of(input int w);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_WORDS; i++) l[i*32 +: 32] = s_word[w][i];
        return l;
    endfunction

    // One complete stage-2 transaction against the model; all checks inline.
    task automatic do_txn(input string name, input logic wr, input logic cached,
                          input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        int hw, v, wi, cyc;
        logic [TAG_W-1:0] t;
        logic [LINE_W-1:0] rl, exp_fill;
        logic [31:0] ucd;
        t  = addr[31 -: TAG_W];
        wi = int'(addr[4:2]);
        hw = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (s_valid[w] && s_tag[w] == t) hw = w;
        @(negedge clk);
        drive_set();
        req_valid = 1; req_wr = wr; req_cached = cached; req_wen = wen; req_paddr = addr; req_wdata = wdata;
        #1;
        if (cached && hw >= 0) begin
            n_checks++;
            if (stall_o !== 1'b0) begin n_fail++; $display("FAIL %s hit_stall: got %b want 0", name, stall_o); end
            if (!wr) begin
                n_checks++;
                if (rdata_valid_o !== 1'b1 || rdata_o !== s_word[hw][wi]) begin
                    n_fail++; $display("FAIL %s hit_rdata: got %b/%h want 1/%h", name, rdata_valid_o, rdata_o, s_word[hw][wi]);
                end
            end else begin
                n_checks++;
                if (hit_we_o !== 1'b1 || way_o !== 2'(hw)) begin
                    n_fail++; $display("FAIL %s hit_we: got %b way %0d want 1 way %0d", name, hit_we_o, way_o, hw);
                end
            end
            @(negedge clk); req_valid = 0; #1;
            n_checks++;
            if (hit_we_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL %s hit_one_cycle: got we %b rv %b want 0 0", name, hit_we_o, rdata_valid_o);
            end
        end else if (cached) begin
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!s_valid[w]) v = w;
            if (v < 0) v = m_rr;
            n_checks++;
            if (stall_o !== 1'b1) begin n_fail++; $display("FAIL %s miss_stall: got %b want 1", name, stall_o); end
            if (s_valid[v] && s_dirty[v]) begin
                cyc = 0;
                while (axi_wreq_o !== 1'b1 && cyc < 20) begin @(negedge clk); #1; cyc++; end
                n_checks++;
                if (axi_wreq_o !== 1'b1) begin n_fail++; $display("FAIL %s wb_req: got %b want 1", name, axi_wreq_o); end
                n_checks++;
                if (axi_waddr_o !== {s_tag[v], addr[10:5], 5'b0}) begin
                    n_fail++; $display("FAIL %s wb_addr: got %h want %h", name, axi_waddr_o, {s_tag[v], addr[10:5], 5'b0});
                end
                n_checks++;
                if (axi_wline_o !== line_of(v)) begin
                    n_fail++; $display("FAIL %s wb_line: got %h want %h", name, axi_wline_o, line_of(v));
                end
                @(negedge clk); axi_rend_i = 1;
                @(negedge clk); axi_rend_i = 0; #1;
                n_checks++;
                if (axi_wreq_o !== 1'b1 || axi_rreq_o !== 1'b0) begin
                    n_fail++; $display("FAIL %s wb_ignore_rend: got w %b r %b want 1 0", name, axi_wreq_o, axi_rreq_o);
                end
                repeat ($urandom_range(2)) @(negedge clk);
                axi_wend_i = 1;
                @(negedge clk); axi_wend_i = 0;
            end
            cyc = 0;
            while (axi_rreq_o !== 1'b1 && cyc < 20) begin @(negedge clk); #1; cyc++; end
            n_checks++;
            if (axi_rreq_o !== 1'b1 || axi_wreq_o !== 1'b0 || stall_o !== 1'b1) begin
                n_fail++; $display("FAIL %s refill_req: got r %b w %b st %b want 1 0 1", name, axi_rreq_o, axi_wreq_o, stall_o);
            end
            n_checks++;
            if (axi_raddr_o !== {addr[31:5], 5'b0}) begin
                n_fail++; $display("FAIL %s refill_addr: got %h want %h", name, axi_raddr_o, {addr[31:5], 5'b0});
            end
            repeat ($urandom_range(3)) @(negedge clk);
            for (int i = 0; i < LINE_WORDS; i++) rl[i*32 +: 32] = $urandom;
            axi_rline_i = rl; axi_rend_i = 1;
            @(negedge clk); axi_rend_i = 0; #1;
            exp_fill = rl;
            if (wr) for (int b = 0; b < 4; b++) if (wen[b]) exp_fill[wi*32 + b*8 +: 8] = wdata[b*8 +: 8];
            n_checks++;
            if (fill_we_o !== 1'b1 || way_o !== 2'(v) || stall_o !== 1'b0) begin
                n_fail++; $display("FAIL %s fill_ctl: got we %b way %0d st %b want 1 %0d 0", name, fill_we_o, way_o, stall_o, v);
            end
            n_checks++;
            if (fill_line_o !== exp_fill || fill_dirty_o !== wr) begin
                n_fail++; $display("FAIL %s fill_line: got %h d%b want %h d%b", name, fill_line_o, fill_dirty_o, exp_fill, wr);
            end
            m_rr = (m_rr + 1) % WAYS;
            @(negedge clk); req_valid = 0; #1;
            n_checks++;
            if (fill_we_o !== 1'b0 || rdata_valid_o !== !wr || (!wr && rdata_o !== rl[wi*32 +: 32])) begin
                n_fail++; $display("FAIL %s miss_rdata: got fw %b rv %b %h want 0 %b %h", name, fill_we_o, rdata_valid_o, rdata_o, !wr, rl[wi*32 +: 32]);
            end
            cpu_ack_i = !wr;
            @(negedge clk); cpu_ack_i = 0; #1;
            n_checks++;
            if (rdata_valid_o !== 1'b0) begin n_fail++; $display("FAIL %s miss_ack: got %b want 0", name, rdata_valid_o); end
        end else begin
            n_checks++;
            if (stall_o !== 1'b1) begin n_fail++; $display("FAIL %s uc_stall: got %b want 1", name, stall_o); end
            cyc = 0;
            while ((wr ? uc_wreq_o : uc_rreq_o) !== 1'b1 && cyc < 20) begin @(negedge clk); #1; cyc++; end
            n_checks++;
            if (uc_rreq_o !== !wr || uc_wreq_o !== wr) begin
                n_fail++; $display("FAIL %s uc_req: got r %b w %b want %b %b", name, uc_rreq_o, uc_wreq_o, !wr, wr);
            end
            n_checks++;
            if (uc_addr_o !== addr || uc_wen_o !== (wr ? wen : 4'hF) || (wr && uc_wdata_o !== wdata)) begin
                n_fail++; $display("FAIL %s uc_fields: got %h %b %h want %h %b %h", name, uc_addr_o, uc_wen_o, uc_wdata_o, addr, wr ? wen : 4'hF, wdata);
            end
            repeat ($urandom_range(3)) @(negedge clk);
            #1;
            n_checks++;
            if ((wr ? uc_wreq_o : uc_rreq_o) !== 1'b1 || stall_o !== 1'b1) begin
                n_fail++; $display("FAIL %s uc_hold: got %b st %b want 1 1", name, wr ? uc_wreq_o : uc_rreq_o, stall_o);
            end
            ucd = $urandom; uc_rdata_i = ucd;
            if (wr) uc_wend_i = 1; else uc_rend_i = 1;
            @(negedge clk); uc_rend_i = 0; uc_wend_i = 0; #1;
            n_checks++;
            if (stall_o !== 1'b0 || uc_rreq_o !== 1'b0 || uc_wreq_o !== 1'b0) begin
                n_fail++; $display("FAIL %s uc_done: got st %b r %b w %b want 0 0 0", name, stall_o, uc_rreq_o, uc_wreq_o);
            end
            n_checks++;
            if (rdata_valid_o !== !wr || (!wr && rdata_o !== ucd)) begin
                n_fail++; $display("FAIL %s uc_rdata: got %b %h want %b %h", name, rdata_valid_o, rdata_o, !wr, ucd);
            end
            @(negedge clk); req_valid = 0; #1;
            if (!wr) begin
                n_checks++;
                if (rdata_valid_o !== 1'b1 || rdata_o !== ucd) begin
                    n_fail++; $display("FAIL %s uc_held: got %b %h want 1 %h", name, rdata_valid_o, rdata_o, ucd);
                end
                cpu_ack_i = 1;
                @(negedge clk); cpu_ack_i = 0; #1;
                n_checks++;
                if (rdata_valid_o !== 1'b0) begin n_fail++; $display("FAIL %s uc_ack: got %b want 0", name, rdata_valid_o); end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({stall_o, axi_rreq_o, axi_wreq_o, uc_rreq_o, uc_wreq_o, hit_we_o, fill_we_o, rdata_valid_o} !== 8'h00
            || rdata_o !== 32'h0 || way_o !== 2'd0) begin
            n_fail++; $display("FAIL reset_outputs: got ctl %b rdata %h want 0", {stall_o, axi_rreq_o, axi_wreq_o, uc_rreq_o, uc_wreq_o, hit_we_o, fill_we_o, rdata_valid_o}, rdata_o);
        end
        @(negedge clk); rst_n = 1; #1;
        n_checks++;
        if (stall_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got st %b rv %b want 0 0", stall_o, rdata_valid_o);
        end
        m_rr = 0;
    endtask

    task automatic test_load_hit();
        logic [31:0] a;
        a = {21'h0A5A5, 6'd17, 3'd3, 2'b00};
        rand_set(a[31 -: TAG_W]);
        s_tag[2] = a[31 -: TAG_W]; s_valid[2] = 1;
        do_txn("load_hit_way2", 1'b0, 1'b1, 4'hF, a, 32'h0);
    endtask

    task automatic test_store_hit();
        logic [31:0] a;
        a = {21'h12345, 6'd5, 3'd6, 2'b00};
        rand_set(a[31 -: TAG_W]);
        s_tag[1] = a[31 -: TAG_W]; s_valid[1] = 1;
        do_txn("store_hit_way1", 1'b1, 1'b1, 4'b0011, a, 32'hDEAD_BEEF);
    endtask

    task automatic test_store_miss_invalid();
        logic [31:0] a;
        a = {21'h00777, 6'd9, 3'd2, 2'b00};
        rand_set(a[31 -: TAG_W]);
        for (int w = 0; w < 3; w++) begin s_valid[w] = 1; s_dirty[w] = 1; end
        s_valid[3] = 0;
        do_txn("store_miss_inv3", 1'b1, 1'b1, 4'b0101, a, 32'hCAFE_F00D);
    endtask

    task automatic test_dirty_miss();
        logic [31:0] a;
        a = {21'h1F00F, 6'd33, 3'd5, 2'b00};
        rand_set(a[31 -: TAG_W]);
        for (int w = 0; w < WAYS; w++) begin s_valid[w] = 1; s_dirty[w] = 1; end
        do_txn("load_miss_dirty", 1'b0, 1'b1, 4'hF, a, 32'h0);
    endtask

    task automatic test_uncached();
        rand_set('0);
        do_txn("uc_load", 1'b0, 1'b0, 4'hF, 32'h1FAF_0004, 32'h0);
        do_txn("uc_store", 1'b1, 1'b0, 4'b1100, 32'h1FAF_0102, 32'h1234_5678);
    endtask

    task automatic test_ack_collision();
        logic [31:0] d1, d2;
        int cyc;
        rand_set('0); drive_set();
        @(negedge clk);
        req_valid = 1; req_wr = 0; req_cached = 0; req_wen = 4'hF; req_paddr = 32'h1000_0010;
        cyc = 0;
        while (uc_rreq_o !== 1'b1 && cyc < 20) begin @(negedge clk); #1; cyc++; end
        d1 = $urandom; uc_rdata_i = d1; uc_rend_i = 1;
        @(negedge clk); uc_rend_i = 0;
        @(negedge clk); req_paddr = 32'h1000_0020; #1;
        n_checks++;
        if (rdata_valid_o !== 1'b1 || rdata_o !== d1 || stall_o !== 1'b1) begin
            n_fail++; $display("FAIL collide_old_held: got %b %h st %b want 1 %h 1", rdata_valid_o, rdata_o, stall_o, d1);
        end
        cyc = 0;
        while (uc_rreq_o !== 1'b1 && cyc < 20) begin @(negedge clk); #1; cyc++; end
        n_checks++;
        if (uc_addr_o !== 32'h1000_0020) begin n_fail++; $display("FAIL collide_addr: got %h want 10000020", uc_addr_o); end
        d2 = $urandom; uc_rdata_i = d2; uc_rend_i = 1; cpu_ack_i = 1;
        @(negedge clk); uc_rend_i = 0; cpu_ack_i = 0; #1;
        n_checks++;
        if (rdata_valid_o !== 1'b1 || rdata_o !== d2) begin
            n_fail++; $display("FAIL collide_new_wins: got %b %h want 1 %h", rdata_valid_o, rdata_o, d2);
        end
        @(negedge clk); req_valid = 0; cpu_ack_i = 1;
        @(negedge clk); cpu_ack_i = 0;
    endtask

    task automatic test_ignored_ends();
        @(negedge clk);
        req_valid = 0; axi_rend_i = 1; axi_wend_i = 1; uc_rend_i = 1; uc_wend_i = 1;
        @(negedge clk);
        axi_rend_i = 0; axi_wend_i = 0; uc_rend_i = 0; uc_wend_i = 0; #1;
        n_checks++;
        if ({stall_o, axi_rreq_o, axi_wreq_o, uc_rreq_o, uc_wreq_o, fill_we_o, rdata_valid_o} !== 7'h00) begin
            n_fail++; $display("FAIL idle_ignore_ends: got %b want 0", {stall_o, axi_rreq_o, axi_wreq_o, uc_rreq_o, uc_wreq_o, fill_we_o, rdata_valid_o});
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] a;
        int cyc;
        a = {21'h0BEEF, 6'd2, 3'd1, 2'b00};
        rand_set(a[31 -: TAG_W]);
        s_valid[0] = 0; drive_set();
        @(negedge clk);
        req_valid = 1; req_wr = 0; req_cached = 1; req_wen = 4'hF; req_paddr = a;
        cyc = 0;
        while (axi_rreq_o !== 1'b1 && cyc < 20) begin @(negedge clk); #1; cyc++; end
        n_checks++;
        if (axi_rreq_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach_refill: got %b want 1", axi_rreq_o); end
        #1 rst_n = 0; #1;
        n_checks++;
        if (axi_rreq_o !== 1'b0 || stall_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_async: got r %b st %b want 0 0", axi_rreq_o, stall_o);
        end
        req_valid = 0;
        @(negedge clk); rst_n = 1; #1;
        n_checks++;
        if (axi_rreq_o !== 1'b0 || stall_o !== 1'b0 || fill_we_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_idle: got r %b st %b fw %b want 0 0 0", axi_rreq_o, stall_o, fill_we_o);
        end
        m_rr = 0;
        rand_set(a[31 -: TAG_W]);
        for (int w = 0; w < WAYS; w++) s_valid[w] = 1;
        do_txn("post_reset_rr0", 1'b0, 1'b1, 4'hF, a, 32'h0);
    endtask

    task automatic test_random(input int n);
        logic [31:0] a;
        int kind, hw;
        for (int k = 0; k < n; k++) begin
            a = $urandom;
            kind = $urandom_range(99);
            rand_set(a[31 -: TAG_W]);
            if (kind < 40) begin
                hw = $urandom_range(WAYS - 1);
                s_tag[hw] = a[31 -: TAG_W]; s_valid[hw] = 1;
            end
            do_txn("random", 1'($urandom_range(1)), kind < 85, 4'($urandom_range(15)), a, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_load_hit();
        test_store_hit();
        test_store_miss_invalid();
        test_dirty_miss();
        test_uncached();
        test_ack_collision();
        test_ignored_ends();
        test_random(40);
        test_reset_mid_refill();
        test_random(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
